imem_load_arbiter: RTL and testbench

//  Owns the single IMEM access port (Addr_64, Inst_in, IMEM_WE, Inst_out) and shares it between core fetch and a host loader.

---
 rtl/imem_load_arbiter_pkg.sv | 17 +
 rtl/imem_load_arbiter_if.sv | 28 ++
 rtl/imem_load_arbiter.sv | 158 +++++++++++++++
 tb/tb_imem_load_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_arbiter_pkg.sv
// Shared constants and the state type for the IMEM load arbiter.
package imem_load_arbiter_pkg;

    localparam int WORD_BITS       = 32;
    localparam int DATA_BITS       = 64;
    localparam int IMEM_IDX_BITS   = 12;
    localparam int LDARB_FLUSH_CYC = 2;

    localparam logic [WORD_BITS-1:0] RV_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        LDARB_RUN   = 2'd0,
        LDARB_LOAD  = 2'd1,
        LDARB_FLUSH = 2'd2
    } ldarb_state_e;

endpackage

// File: rtl/imem_load_arbiter_if.sv
// Host loader bundle: start/base/count command, valid/ready word stream, status.
interface imem_load_arbiter_if
    import imem_load_arbiter_pkg::*;
#(
    parameter int IDX_BITS = IMEM_IDX_BITS
) ();

    logic                 ld_start;
    logic [DATA_BITS-1:0] ld_base;
    logic [IDX_BITS:0]    ld_count;
    logic                 ld_valid;
    logic [WORD_BITS-1:0] ld_data;
    logic                 ld_ready;
    logic                 ld_busy;
    logic                 ld_done;
    logic [WORD_BITS-1:0] ld_csum;

    modport master (
        output ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  ld_ready, ld_busy, ld_done, ld_csum
    );

    modport slave (
        input  ld_start, ld_base, ld_count, ld_valid, ld_data,
        output ld_ready, ld_busy, ld_done, ld_csum
    );

endinterface

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the single IMEM port between core fetch and a
// host program loader. While a load is running the core is stalled and sees
// NOPs; after the last word a short flush precedes release of the core.
// Optional feature macro: IMEM_LOAD_CSUM_EN (running checksum on ld_csum).
module imem_load_arbiter
    import imem_load_arbiter_pkg::*;
#(
    parameter int                   IDX_BITS  = IMEM_IDX_BITS,
    parameter logic [WORD_BITS-1:0] NOP_INST  = RV_NOP_INST,
    parameter int                   FLUSH_CYC = LDARB_FLUSH_CYC
) (
    input  logic                 CLK,
    input  logic                 RST,
    imem_load_arbiter_if.slave   ld,
    input  logic [DATA_BITS-1:0] core_pc,
    output logic [WORD_BITS-1:0] core_inst,
    output logic                 core_stall,
    output logic [DATA_BITS-1:0] imem_addr,
    output logic [WORD_BITS-1:0] imem_wdata,
    output logic                 imem_we,
    input  logic [WORD_BITS-1:0] imem_rdata
);

    localparam int                FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FLUSH_CYC - 1);
    localparam logic [FC_W-1:0]   FC_ONE  = FC_W'(1);
    localparam logic [IDX_BITS:0] CNT_MAX = {1'b1, {IDX_BITS{1'b0}}};
    localparam logic [IDX_BITS:0] CNT_ONE = {{IDX_BITS{1'b0}}, 1'b1};
    localparam logic [IDX_BITS-1:0] PTR_ONE = {{(IDX_BITS-1){1'b0}}, 1'b1};

    ldarb_state_e        state_r;
    logic [IDX_BITS-1:0] ptr_r;
    logic [IDX_BITS:0]   remaining_r;
    logic [FC_W-1:0]     flush_cnt_r;
    logic                ld_ready_r;
    logic                ld_busy_r;
    logic                ld_done_r;
    logic                core_stall_r;

    logic                xfer_s;
    logic [IDX_BITS:0]   count_clamped_s;
    logic                unused_s;

    // Only byte-address bits that select an IMEM word matter for the base.
    assign unused_s = ^{ld.ld_base[DATA_BITS-1:IDX_BITS+2], ld.ld_base[1:0]};

    // A word transfers on valid&ready; reset suppresses any write that cycle.
    assign xfer_s = ld_ready_r & ld.ld_valid & ~RST;

    // Requests larger than the whole IMEM are limited to one full pass.
    assign count_clamped_s = (ld.ld_count > CNT_MAX) ? CNT_MAX : ld.ld_count;

    // Control FSM with registered status outputs derived from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= LDARB_RUN;
            ptr_r        <= '0;
            remaining_r  <= '0;
            flush_cnt_r  <= '0;
            ld_ready_r   <= 1'b0;
            ld_busy_r    <= 1'b0;
            ld_done_r    <= 1'b0;
            core_stall_r <= 1'b0;
        end else begin
            ld_done_r <= 1'b0;
            case (state_r)
                LDARB_RUN: begin
                    if (ld.ld_start) begin
                        ptr_r        <= ld.ld_base[IDX_BITS+1:2];
                        remaining_r  <= count_clamped_s;
                        flush_cnt_r  <= '0;
                        ld_busy_r    <= 1'b1;
                        core_stall_r <= 1'b1;
                        if (count_clamped_s == '0) begin
                            state_r    <= LDARB_FLUSH;
                            ld_ready_r <= 1'b0;
                        end else begin
                            state_r    <= LDARB_LOAD;
                            ld_ready_r <= 1'b1;
                        end
                    end
                end
                LDARB_LOAD: begin
                    if (xfer_s) begin
                        ptr_r       <= ptr_r + PTR_ONE;
                        remaining_r <= remaining_r - CNT_ONE;
                        if (remaining_r == CNT_ONE) begin
                            state_r     <= LDARB_FLUSH;
                            ld_ready_r  <= 1'b0;
                            flush_cnt_r <= '0;
                        end
                    end
                end
                LDARB_FLUSH: begin
                    if (flush_cnt_r == FC_LAST) begin
                        state_r      <= LDARB_RUN;
                        flush_cnt_r  <= '0;
                        ld_busy_r    <= 1'b0;
                        core_stall_r <= 1'b0;
                        ld_done_r    <= 1'b1;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + FC_ONE;
                    end
                end
                default: begin
                    state_r      <= LDARB_RUN;
                    flush_cnt_r  <= '0;
                    ld_ready_r   <= 1'b0;
                    ld_busy_r    <= 1'b0;
                    core_stall_r <= 1'b0;
                end
            endcase
        end
    end

    // IMEM port steering and core instruction mux (same-cycle by design).
    always_comb begin
        imem_we    = xfer_s;
        imem_wdata = ld.ld_data;
        if (ld_ready_r) begin
            imem_addr = {{(DATA_BITS-IDX_BITS-2){1'b0}}, ptr_r, 2'b00};
        end else begin
            imem_addr = core_pc;
        end
        if (core_stall_r) begin
            core_inst = NOP_INST;
        end else begin
            core_inst = imem_rdata;
        end
    end

    assign core_stall  = core_stall_r;
    assign ld.ld_ready = ld_ready_r;
    assign ld.ld_busy  = ld_busy_r;
    assign ld.ld_done  = ld_done_r;

`ifdef IMEM_LOAD_CSUM_EN
    logic [WORD_BITS-1:0] csum_r;

    // Running mod-2^32 sum of transferred words, restarted by each new load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            csum_r <= '0;
        end else if ((state_r == LDARB_RUN) && ld.ld_start) begin
            csum_r <= '0;
        end else if (xfer_s) begin
            csum_r <= csum_r + ld.ld_data;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign ld.ld_csum = csum_r;
`else
    assign ld.ld_csum = {WORD_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench for imem_load_arbiter with a behavioural IMEM and a
// reference memory image kept by the bench.
module tb_imem_load_arbiter;
    import imem_load_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] core_pc;
    logic [31:0] core_inst;
    logic        core_stall;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_we;
    logic [31:0] imem_rdata;

    logic        clr;
    logic        bd_we;
    logic [11:0] bd_idx;
    logic [31:0] bd_data;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] ld_words[0:4095];

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    imem_load_arbiter_if ld_if ();

    imem_load_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .ld         (ld_if),
        .core_pc    (core_pc),
        .core_inst  (core_inst),
        .core_stall (core_stall),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .imem_rdata (imem_rdata)
    );

    assign imem_rdata = mem[imem_addr[13:2]];

    always @(posedge CLK) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
        end else if (imem_we) begin
            mem[imem_addr[13:2]] <= imem_wdata;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bd_write(input logic [11:0] idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        step();
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic rd_check(input string name, input logic [11:0] idx);
        core_pc = {$urandom, 32'h0} | {50'h0, idx, 2'b00};
        core_pc[13:0] = {idx, 2'b00};
        @(negedge CLK);
        chk(name, core_inst, ref_mem[idx]);
        chk({name, "_stall"}, core_stall, 1'b0);
        step();
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] s);
`ifdef IMEM_LOAD_CSUM_EN
        return s;
`else
        return 32'h0 & s;
`endif
    endfunction

    // One complete load: command, word stream gated by vmask, flush, done.
    task automatic do_load(input string tag, input logic [63:0] base,
                           input logic [12:0] count, input logic [31:0] vmask);
        int          n;
        int          k;
        int          cyc;
        logic [11:0] idx0;
        logic [11:0] ei;
        logic [31:0] sum;
        logic        v;
        n    = (count > 13'd4096) ? 4096 : int'(count);
        idx0 = base[13:2];
        sum  = 32'h0;
        k    = 0;
        cyc  = 0;
        ld_if.ld_start = 1'b1;
        ld_if.ld_base  = base;
        ld_if.ld_count = count;
        @(negedge CLK);
        chk({tag, "_start_busy"}, ld_if.ld_busy, 1'b0);
        step();
        ld_if.ld_start = 1'b0;
        while (k < n && cyc < 20000) begin
            v = (cyc < 32) ? vmask[cyc] : 1'b1;
            ld_if.ld_valid = v;
            ld_if.ld_data  = ld_words[k];
            core_pc        = {$urandom, $urandom};
            @(negedge CLK);
            ei = idx0 + 12'(k);
            chk({tag, "_ld_ready"}, ld_if.ld_ready, 1'b1);
            chk({tag, "_ld_stall"}, core_stall, 1'b1);
            chk({tag, "_ld_nop"}, core_inst, 32'h13);
            chk({tag, "_ld_addr"}, imem_addr, {50'h0, ei, 2'b00});
            chk({tag, "_ld_we"}, imem_we, v);
            if (v) begin
                chk({tag, "_ld_wdata"}, imem_wdata, ld_words[k]);
                ref_mem[ei] = ld_words[k];
                sum = sum + ld_words[k];
                k++;
            end
            step();
            cyc++;
        end
        if (cyc >= 20000) chk({tag, "_load_timeout"}, 64'(k), 64'(n));
        for (int i = 0; i < 2; i++) begin
            ld_if.ld_valid = 1'b1;
            ld_if.ld_data  = $urandom;
            ld_if.ld_start = 1'b1;
            core_pc        = {$urandom, $urandom};
            @(negedge CLK);
            chk({tag, "_fl_ready"}, ld_if.ld_ready, 1'b0);
            chk({tag, "_fl_we"}, imem_we, 1'b0);
            chk({tag, "_fl_busy"}, ld_if.ld_busy, 1'b1);
            chk({tag, "_fl_done"}, ld_if.ld_done, 1'b0);
            chk({tag, "_fl_nop"}, core_inst, 32'h13);
            chk({tag, "_fl_addr"}, imem_addr, core_pc);
            step();
        end
        ld_if.ld_valid = 1'b0;
        ld_if.ld_start = 1'b0;
        @(negedge CLK);
        chk({tag, "_done"}, ld_if.ld_done, 1'b1);
        chk({tag, "_run_busy"}, ld_if.ld_busy, 1'b0);
        chk({tag, "_run_stall"}, core_stall, 1'b0);
        chk({tag, "_csum"}, ld_if.ld_csum, exp_csum(sum));
        step();
        @(negedge CLK);
        chk({tag, "_done_pulse"}, ld_if.ld_done, 1'b0);
        step();
        for (int i = 0; i < ((n < 6) ? n : 6); i++) rd_check({tag, "_rb"}, idx0 + 12'(i));
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [31:0] val;
        logic [31:0] exp_inst;
    } run_vec_t;

    run_vec_t rv [6];

    initial begin
        logic [31:0] keep [1:3];
        RST = 1'b1;
        clr = 1'b1;
        bd_we = 1'b0; bd_idx = 12'h0; bd_data = 32'h0;
        core_pc = 64'h0;
        ld_if.ld_start = 1'b0; ld_if.ld_base = 64'h0; ld_if.ld_count = 13'h0;
        ld_if.ld_valid = 1'b0; ld_if.ld_data = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
        step();
        clr = 1'b0;
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", ld_if.ld_ready, 1'b0);
        chk("rst_busy", ld_if.ld_busy, 1'b0);
        chk("rst_done", ld_if.ld_done, 1'b0);
        chk("rst_csum", ld_if.ld_csum, 32'h0);
        chk("rst_stall", core_stall, 1'b0);
        chk("rst_we", imem_we, 1'b0);
        step();

        // RUN passthrough vectors
        rv[0] = '{64'h10, 32'hDEADBEEF, 32'hDEADBEEF};
        rv[1] = '{64'h0, 32'h1234_5678, 32'h1234_5678};
        rv[2] = '{64'h3FFC, 32'hCAFE_F00D, 32'hCAFE_F00D};
        rv[3] = '{64'h8, 32'h0000_0013, 32'h0000_0013};
        rv[4] = '{64'hFFFF_0000_0000_0204, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        rv[5] = '{64'h0000_0000_0000_0013, 32'h7777_0001, 32'h7777_0001};
        for (int i = 0; i < 6; i++) begin
            bd_write(rv[i].pc[13:2], rv[i].val);
            core_pc = rv[i].pc;
            @(negedge CLK);
            chk("run_inst", core_inst, rv[i].exp_inst);
            chk("run_stall", core_stall, 1'b0);
            chk("run_we", imem_we, 1'b0);
            chk("run_addr", imem_addr, rv[i].pc);
            step();
        end

        // Three words with a one-cycle valid gap
        ld_words[0] = 32'hAAAA_0001; ld_words[1] = 32'hBBBB_0002; ld_words[2] = 32'hCCCC_0003;
        do_load("t2", 64'h100, 13'd3, 32'hFFFF_FFFD);
        chk("t2_mem64", mem[64], 32'hAAAA_0001);
        chk("t2_mem65", mem[65], 32'hBBBB_0002);
        chk("t2_mem66", mem[66], 32'hCCCC_0003);

        // Zero-length load
        do_load("t3", 64'h200, 13'd0, 32'hFFFF_FFFF);

        // Pointer wrap 4095 -> 0
        ld_words[0] = 32'h0F0F_0F0F; ld_words[1] = 32'hF0F0_F0F0;
        do_load("t4", 64'h3FFC, 13'd2, 32'hFFFF_FFFF);
        chk("t4_mem4095", mem[4095], 32'h0F0F_0F0F);
        chk("t4_mem0", mem[0], 32'hF0F0_F0F0);

        // Checksum wrap
        ld_words[0] = 32'hFFFF_FFFF; ld_words[1] = 32'h0000_0002;
        do_load("t6", 64'h400, 13'd2, 32'hFFFF_FFFF);
        chk("t6_csum", ld_if.ld_csum, exp_csum(32'h1));

        // Reset mid-load, with an ignored ld_start while loading
        for (int i = 1; i <= 3; i++) begin
            keep[i] = 32'h5000_0000 + 32'(i);
            bd_write(12'(i), keep[i]);
        end
        ld_if.ld_start = 1'b1; ld_if.ld_base = 64'h0; ld_if.ld_count = 13'd4;
        step();
        ld_if.ld_start = 1'b0; ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'h1111_2222;
        @(negedge CLK);
        chk("t5_we0", imem_we, 1'b1);
        chk("t5_addr0", imem_addr, 64'h0);
        step();
        ld_if.ld_valid = 1'b0; ld_if.ld_start = 1'b1; ld_if.ld_base = 64'h800; ld_if.ld_count = 13'd1;
        step();
        ld_if.ld_start = 1'b0;
        @(negedge CLK);
        chk("t5_still_ready", ld_if.ld_ready, 1'b1);
        chk("t5_ignore_start", imem_addr, 64'h4);
        step();
        RST = 1'b1; ld_if.ld_valid = 1'b1; ld_if.ld_data = 32'hBAD0_BAD0;
        @(negedge CLK);
        chk("t5_rst_we", imem_we, 1'b0);
        step();
        RST = 1'b0; ld_if.ld_valid = 1'b0;
        @(negedge CLK);
        chk("t5_busy", ld_if.ld_busy, 1'b0);
        chk("t5_done", ld_if.ld_done, 1'b0);
        chk("t5_stall", core_stall, 1'b0);
        chk("t5_ready", ld_if.ld_ready, 1'b0);
        chk("t5_csum", ld_if.ld_csum, 32'h0);
        step();
        @(negedge CLK);
        chk("t5_done2", ld_if.ld_done, 1'b0);
        step();
        chk("t5_mem0", mem[0], 32'h1111_2222);
        for (int i = 1; i <= 3; i++) chk("t5_keep", mem[i], keep[i]);
        ref_mem[0] = 32'h1111_2222;

        // Count above depth is limited to 4096 words
        for (int i = 0; i < 4096; i++) ld_words[i] = $urandom;
        do_load("clamp", 64'h40, 13'd5000, 32'hFFFF_FFFF);

        // Randomised loads against the reference image
        for (int t = 0; t < 20; t++) begin
            logic [12:0] cnt;
            cnt = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 40));
            for (int i = 0; i < 40; i++) ld_words[i] = $urandom;
            do_load("rnd", {$urandom, $urandom}, cnt, $urandom);
            for (int j = 0; j < 3; j++) rd_check("rnd_run", 12'($urandom_range(0, 4095)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
